// File: rtl/fetch_pkg.sv
// Shared state type, opcode constant and halfword helpers for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_LO,
        REQ_HI,
        DRAIN,
        VALID
    } FetchState;

    localparam logic [1:0] OPC_QUAD_FULL = 2'b11;

    // Picks the halfword of a memory word addressed by byte-address bit 1.
    function automatic logic [15:0] selectHalf(input logic [31:0] word, input logic upper);
        return upper ? word[31:16] : word[15:0];
    endfunction

    function automatic logic isFullWidth(input logic [15:0] half);
        return half[1:0] == OPC_QUAD_FULL;
    endfunction

endpackage

// File: rtl/fetch_word_buf.sv
// One-word instruction buffer: tag/data/valid storage with lookup and clear.
module fetch_word_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        wrEn,
    input  logic [29:0] wrTag,
    input  logic [31:0] wrData,
    input  logic [29:0] lookupTag,
    output logic        hit,
    output logic [31:0] rdData
);

    logic        bufValid;
    logic [29:0] bufTag;
    logic [31:0] bufData;

    // A clear wins over a simultaneous write so fence.i never leaves a live entry behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bufValid <= 1'b0;
            bufTag   <= '0;
            bufData  <= '0;
        end else begin
            if (wrEn) begin
                bufTag  <= wrTag;
                bufData <= wrData;
            end
            bufValid <= clear ? 1'b0 : (wrEn | bufValid);
        end
    end

    // A lookup in the same cycle as a clear already sees the buffer as empty.
    assign hit    = bufValid && !clear && (bufTag == lookupTag);
    assign rdData = bufData;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reassembles 16/32-bit RV32EC instructions from 32-bit memory words.
// Define FETCH_WORD_BUF_EN to add a one-word buffer that skips re-reading the last fetched word.
module instr_fetch
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] FetchAddr,
    input  logic        FetchReq,
    input  logic        InstrReady,
    input  logic        Invalidate,
    output logic [31:0] MemAddr,
    output logic        MemReq,
    input  logic        MemAck,
    input  logic [31:0] MemRData,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic        Compressed,
    output logic        FetchFault,
    output logic        FetchBusy
);

    FetchState   state;
    logic [31:1] curAddr;
    logic [31:0] pendAddr;
    logic [15:0] halfLo;

    logic [31:0] startAddr;
    logic        doLaunch;
    logic        bufHit;
    logic [31:0] bufWord;
    logic        bufWrite;
    logic [29:0] bufWrTag;
    logic [15:0] ackHalf;
    logic [15:0] hitHalf;

    FetchState   launchState;
    logic        launchReq;
    logic [31:0] launchMemAddr;
    logic [31:0] launchInstr;
    logic        launchFault;

    // The pending redirect target is used only when draining without a newer request.
    assign startAddr = (state == DRAIN && !FetchReq) ? pendAddr : FetchAddr;

    assign doLaunch = (state == IDLE && FetchReq)
                   || (state == VALID && InstrReady && FetchReq)
                   || (state == DRAIN && MemAck)
                   || ((state == REQ_LO || state == REQ_HI) && MemAck && FetchReq);

    assign bufWrite = MemAck && !FetchReq && (state == REQ_LO || state == REQ_HI);
    assign bufWrTag = (state == REQ_HI) ? curAddr[31:2] + 30'd1 : curAddr[31:2];

`ifdef FETCH_WORD_BUF_EN
    fetch_word_buf wordBuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (Invalidate),
        .wrEn      (bufWrite),
        .wrTag     (bufWrTag),
        .wrData    (MemRData),
        .lookupTag (startAddr[31:2]),
        .hit       (bufHit),
        .rdData    (bufWord)
    );
`else
    logic unusedBufInputs;
    assign unusedBufInputs = ^{Invalidate, bufWrite, bufWrTag};
    assign bufHit  = 1'b0;
    assign bufWord = '0;
`endif

    assign ackHalf = selectHalf(MemRData, curAddr[1]);
    assign hitHalf = selectHalf(bufWord, startAddr[1]);

    // Outcome of accepting a fetch, shared by idle, back-to-back and post-drain starts.
    always_comb begin
        launchState   = REQ_LO;
        launchReq     = 1'b1;
        launchMemAddr = {startAddr[31:2], 2'b00};
        launchInstr   = '0;
        launchFault   = 1'b0;
        if (startAddr[0]) begin
            launchState = VALID;
            launchReq   = 1'b0;
            launchFault = 1'b1;
        end else if (bufHit) begin
            if (!isFullWidth(hitHalf)) begin
                launchState = VALID;
                launchReq   = 1'b0;
                launchInstr = {16'h0, hitHalf};
            end else if (!startAddr[1]) begin
                launchState = VALID;
                launchReq   = 1'b0;
                launchInstr = bufWord;
            end else begin
                launchState   = REQ_HI;
                launchMemAddr = {startAddr[31:2] + 30'd1, 2'b00};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            curAddr    <= '0;
            pendAddr   <= '0;
            halfLo     <= '0;
            MemReq     <= 1'b0;
            MemAddr    <= '0;
            Instr      <= '0;
            InstrValid <= 1'b0;
            Compressed <= 1'b0;
            FetchFault <= 1'b0;
        end else if (doLaunch) begin
            state      <= launchState;
            curAddr    <= startAddr[31:1];
            halfLo     <= hitHalf;
            MemReq     <= launchReq;
            if (launchReq) begin
                MemAddr <= launchMemAddr;
            end
            Instr      <= launchInstr;
            InstrValid <= (launchState == VALID);
            Compressed <= (launchState == VALID) && !launchFault && !isFullWidth(launchInstr[15:0]);
            FetchFault <= launchFault;
        end else begin
            case (state)
                REQ_LO: begin
                    if (MemAck) begin
                        if (!isFullWidth(ackHalf)) begin
                            state      <= VALID;
                            MemReq     <= 1'b0;
                            Instr      <= {16'h0, ackHalf};
                            InstrValid <= 1'b1;
                            Compressed <= 1'b1;
                            FetchFault <= 1'b0;
                        end else if (!curAddr[1]) begin
                            state      <= VALID;
                            MemReq     <= 1'b0;
                            Instr      <= MemRData;
                            InstrValid <= 1'b1;
                            Compressed <= 1'b0;
                            FetchFault <= 1'b0;
                        end else begin
                            state   <= REQ_HI;
                            halfLo  <= ackHalf;
                            MemAddr <= {curAddr[31:2] + 30'd1, 2'b00};
                        end
                    end else if (FetchReq) begin
                        pendAddr <= FetchAddr;
                        state    <= DRAIN;
                    end
                end
                REQ_HI: begin
                    if (MemAck) begin
                        state      <= VALID;
                        MemReq     <= 1'b0;
                        Instr      <= {MemRData[15:0], halfLo};
                        InstrValid <= 1'b1;
                        Compressed <= 1'b0;
                        FetchFault <= 1'b0;
                    end else if (FetchReq) begin
                        pendAddr <= FetchAddr;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (FetchReq) begin
                        pendAddr <= FetchAddr;
                    end
                end
                VALID: begin
                    if (InstrReady) begin
                        state      <= IDLE;
                        InstrValid <= 1'b0;
                    end
                end
                IDLE: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign FetchBusy = (state != IDLE);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed latency/traffic cases, then randomized fetch
// traffic compared against a halfword-stream model of instruction memory.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] FetchAddr;
    logic        FetchReq;
    logic        InstrReady;
    logic        Invalidate;
    logic [31:0] MemAddr;
    logic        MemReq;
    logic        MemAck;
    logic [31:0] MemRData;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        Compressed;
    logic        FetchFault;
    logic        FetchBusy;

    int testCount = 0;
    int failCount = 0;

    logic [31:0] memArr [logic [29:0]];
    logic [31:0] memLog [$];

    bit          inReq;
    int          waitLeft;
    int          maxWait;
    int          fixedWait;
    logic [31:0] reqAddr;

    localparam int STALL_LIMIT = 60;

    instr_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .FetchAddr  (FetchAddr),
        .FetchReq   (FetchReq),
        .InstrReady (InstrReady),
        .Invalidate (Invalidate),
        .MemAddr    (MemAddr),
        .MemReq     (MemReq),
        .MemAck     (MemAck),
        .MemRData   (MemRData),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .Compressed (Compressed),
        .FetchFault (FetchFault),
        .FetchBusy  (FetchBusy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Unwritten words read as random but stay fixed once first seen.
    function automatic logic [31:0] memWord(input logic [29:0] idx);
        if (!memArr.exists(idx)) begin
            memArr[idx] = $urandom;
        end
        return memArr[idx];
    endfunction

    function automatic logic [15:0] halfAt(input logic [31:0] byteAddr);
        logic [31:0] w;
        w = memWord(byteAddr[31:2]);
        return byteAddr[1] ? w[31:16] : w[15:0];
    endfunction

    // Memory viewed as a stream of halfwords; a full-width opcode takes the following halfword.
    function automatic logic [31:0] modelInstr(input logic [31:0] a);
        logic [15:0] lo;
        logic [15:0] hi;
        if (a[0]) begin
            return 32'h0;
        end
        lo = halfAt(a);
        if (lo[1:0] != 2'b11) begin
            return {16'h0, lo};
        end
        hi = halfAt(a + 32'd2);
        return {hi, lo};
    endfunction

    task automatic setMem(input logic [31:0] addr, input logic [31:0] data);
        memArr[addr[31:2]] = data;
    endtask

    // Memory responder: random or fixed wait, also checks request stability until the ack.
    initial begin
        MemAck   = 1'b0;
        MemRData = '0;
        inReq    = 1'b0;
        waitLeft = 0;
        reqAddr  = '0;
        forever begin
            tick();
            MemAck   = 1'b0;
            MemRData = $urandom;
            if (!rst_n) begin
                inReq = 1'b0;
            end else if (!MemReq) begin
                if (inReq) begin
                    checkVal("memReqHeld", {31'b0, MemReq}, 32'd1);
                end
                inReq = 1'b0;
            end else begin
                if (!inReq) begin
                    inReq    = 1'b1;
                    reqAddr  = MemAddr;
                    waitLeft = (fixedWait >= 0) ? fixedWait : int'($urandom_range(0, maxWait));
                    checkVal("memAddrAlign", {30'b0, MemAddr[1:0]}, 32'd0);
                end else begin
                    checkVal("memAddrHeld", MemAddr, reqAddr);
                end
                if (waitLeft == 0) begin
                    MemAck   = 1'b1;
                    MemRData = memWord(MemAddr[31:2]);
                    memLog.push_back(MemAddr);
                    inReq    = 1'b0;
                end else begin
                    waitLeft--;
                end
            end
        end
    end

    // Compare process: the latest requested address decides what must be presented.
    initial begin
        logic [31:0] expAddr;
        logic [31:0] expInstr;
        bit          outstanding;
        int          stallCycles;
        expAddr     = '0;
        outstanding = 1'b0;
        stallCycles = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                outstanding = 1'b0;
                stallCycles = 0;
            end else begin
                checkVal("busy", {31'b0, FetchBusy}, {31'b0, outstanding});
                checkVal("spuriousValid", {31'b0, InstrValid & ~outstanding}, 32'd0);
                if (InstrValid) begin
                    expInstr = modelInstr(expAddr);
                    checkVal("instr", Instr, expInstr);
                    checkVal("compressed", {31'b0, Compressed},
                             {31'b0, !expAddr[0] && (expInstr[1:0] != 2'b11)});
                    checkVal("fault", {31'b0, FetchFault}, {31'b0, expAddr[0]});
                end
                if (outstanding && !InstrValid) begin
                    stallCycles++;
                end else begin
                    stallCycles = 0;
                end
                if (stallCycles == STALL_LIMIT) begin
                    checkVal("fetchProgress", stallCycles, 32'd0);
                end
                if (FetchReq) begin
                    expAddr     = FetchAddr;
                    outstanding = 1'b1;
                end else if (InstrValid && InstrReady) begin
                    outstanding = 1'b0;
                end
            end
        end
    end

    task automatic pulseInvalidate();
        Invalidate = 1'b1;
        tick();
        Invalidate = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] addr);
        memLog.delete();
        FetchAddr = addr;
        FetchReq  = 1'b1;
    endtask

    task automatic waitValid(output int cycles);
        cycles = 0;
        do begin
            tick();
            FetchReq = 1'b0;
            cycles++;
        end while (!InstrValid && cycles < 40);
        checkVal("validArrives", {31'b0, InstrValid}, 32'd1);
    endtask

    task automatic checkOutput(input string name, input int cycles, input logic [31:0] expInstr,
                               input logic expComp, input logic expFault, input int expCycles,
                               input int expReads, input logic [31:0] addr0, input logic [31:0] addr1);
        checkVal({name, ".instr"}, Instr, expInstr);
        checkVal({name, ".compressed"}, {31'b0, Compressed}, {31'b0, expComp});
        checkVal({name, ".fault"}, {31'b0, FetchFault}, {31'b0, expFault});
        if (expCycles > 0) begin
            checkVal({name, ".latency"}, cycles, expCycles);
        end
        checkVal({name, ".reads"}, memLog.size(), expReads);
        if (expReads >= 1) begin
            checkVal({name, ".addr0"}, (memLog.size() > 0) ? memLog[0] : 32'hDEADBEEF, addr0);
        end
        if (expReads >= 2) begin
            checkVal({name, ".addr1"}, (memLog.size() > 1) ? memLog[1] : 32'hDEADBEEF, addr1);
        end
        InstrReady = 1'b1;
        tick();
        InstrReady = 1'b0;
    endtask

    task automatic runFetch(input string name, input logic [31:0] addr, input logic [31:0] expInstr,
                            input logic expComp, input logic expFault, input int expCycles,
                            input int expReads, input logic [31:0] addr0, input logic [31:0] addr1);
        int cycles;
        applyStimulus(addr);
        waitValid(cycles);
        checkOutput(name, cycles, expInstr, expComp, expFault, expCycles, expReads, addr0, addr1);
    endtask

    function automatic logic [31:0] randAddr();
        logic [31:0] a;
        if ($urandom_range(0, 15) == 0) begin
            a = 32'hFFFFFFF8 + 32'(2 * $urandom_range(0, 3));
        end else begin
            a = 32'h1000 + 32'(2 * $urandom_range(0, 23));
        end
        if ($urandom_range(0, 15) == 0) begin
            a[0] = 1'b1;
        end
        return a;
    endfunction

    task automatic midReset();
        rst_n    = 1'b0;
        FetchReq = 1'b0;
        #1;
        checkVal("midRstMemReq", {31'b0, MemReq}, 32'd0);
        checkVal("midRstValid", {31'b0, InstrValid}, 32'd0);
        checkVal("midRstBusy", {31'b0, FetchBusy}, 32'd0);
        inReq = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int cycles;
        int redirects;
        bit midResetDone;
        rst_n      = 1'b0;
        FetchAddr  = '0;
        FetchReq   = 1'b0;
        InstrReady = 1'b0;
        Invalidate = 1'b0;
        maxWait    = 0;
        fixedWait  = 0;

        repeat (3) @(posedge clk);
        #2;
        checkVal("rstMemReq", {31'b0, MemReq}, 32'd0);
        checkVal("rstMemAddr", MemAddr, 32'd0);
        checkVal("rstInstr", Instr, 32'd0);
        checkVal("rstValid", {31'b0, InstrValid}, 32'd0);
        checkVal("rstCompressed", {31'b0, Compressed}, 32'd0);
        checkVal("rstFault", {31'b0, FetchFault}, 32'd0);
        checkVal("rstBusy", {31'b0, FetchBusy}, 32'd0);
        rst_n = 1'b1;
        tick();

        pulseInvalidate();
        setMem(32'h100, 32'h00A00093);
        runFetch("aligned32", 32'h100, 32'h00A00093, 1'b0, 1'b0, 2, 1, 32'h100, 32'h0);

        pulseInvalidate();
        setMem(32'h100, 32'h45010000);
        runFetch("compHalf2", 32'h102, 32'h00004501, 1'b1, 1'b0, 2, 1, 32'h100, 32'h0);

        pulseInvalidate();
        setMem(32'h104, 32'h00931234);
        setMem(32'h108, 32'h567800A0);
        runFetch("split", 32'h106, 32'h00A00093, 1'b0, 1'b0, 3, 2, 32'h104, 32'h108);

        pulseInvalidate();
        setMem(32'hFFFFFFFC, 32'h00930000);
        setMem(32'h00000000, 32'h000000A0);
        runFetch("wrap", 32'hFFFFFFFE, 32'h00A00093, 1'b0, 1'b0, 3, 2, 32'hFFFFFFFC, 32'h0);

        pulseInvalidate();
        runFetch("fault", 32'h101, 32'h0, 1'b0, 1'b1, 1, 0, 32'h0, 32'h0);

        pulseInvalidate();
        setMem(32'h300, 32'h45014505);
        runFetch("bufFill", 32'h300, 32'h00004505, 1'b1, 1'b0, 2, 1, 32'h300, 32'h0);
`ifdef FETCH_WORD_BUF_EN
        runFetch("bufHit", 32'h302, 32'h00004501, 1'b1, 1'b0, 1, 0, 32'h0, 32'h0);
`else
        runFetch("bufHit", 32'h302, 32'h00004501, 1'b1, 1'b0, 2, 1, 32'h300, 32'h0);
`endif
        pulseInvalidate();
        runFetch("afterInval", 32'h302, 32'h00004501, 1'b1, 1'b0, 2, 1, 32'h300, 32'h0);

        pulseInvalidate();
        setMem(32'h100, 32'h00A00093);
        setMem(32'h200, 32'h00004505);
        fixedWait = 3;
        applyStimulus(32'h100);
        tick();
        FetchAddr = 32'h200;
        FetchReq  = 1'b1;
        waitValid(cycles);
        checkOutput("redirect", cycles, 32'h00004505, 1'b1, 1'b0, 0, 2, 32'h100, 32'h200);

        fixedWait    = -1;
        maxWait      = 3;
        redirects    = 0;
        midResetDone = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!midResetDone && cyc >= 1500 && FetchBusy && !InstrValid) begin
                midReset();
                midResetDone = 1'b1;
            end
            Invalidate = ($urandom_range(0, 7) == 0);
            InstrReady = ($urandom_range(0, 1) == 1);
            FetchReq   = 1'b0;
            if (!FetchBusy) begin
                FetchReq = ($urandom_range(0, 1) == 1);
            end else if (InstrValid && InstrReady) begin
                FetchReq = ($urandom_range(0, 1) == 1);
            end else if (!InstrValid && redirects < 2 && $urandom_range(0, 9) == 0) begin
                FetchReq = 1'b1;
                redirects++;
            end
            if (FetchReq) begin
                if (!FetchBusy || InstrValid) begin
                    redirects = 0;
                end
                FetchAddr = randAddr();
            end
            tick();
        end

        FetchReq   = 1'b0;
        Invalidate = 1'b0;
        InstrReady = 1'b1;
        repeat (60) tick();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the multi-cycle RV32EC core. It sits between the program counter's fetch address and the instruction memory port. It reads 32-bit memory words through a request/acknowledge handshake and reassembles 16- and 32-bit instructions at any halfword alignment, including 32-bit instructions split across a word boundary. It hands the decoder one instruction at a time with its `Compressed` flag, which feeds back to the program counter's increment selection.

## Interface
- No parameters; data and address widths are fixed at 32.
- `clk` input 1: single clock for all state.
- `rst_n` input 1: reset, asynchronous, active-low.
- `FetchAddr` input 32: byte address of the next instruction; sampled when `FetchReq` is accepted.
- `FetchReq` input 1: one-cycle strobe requesting a fetch at `FetchAddr`.
- `InstrReady` input 1: decoder consumes `Instr` when high together with `InstrValid`.
- `Invalidate` input 1: clears the word buffer (fence.i).
- `MemAddr` output 32: word address to memory; bits [1:0] are always 0.
- `MemReq` output 1: memory read request, registered.
- `MemAck` input 1: memory has completed the request; `MemRData` is valid in this cycle.
- `MemRData` input 32: read data.
- `Instr` output 32: fetched instruction. A 16-bit instruction is zero-extended.
- `InstrValid` output 1: `Instr`, `Compressed` and `FetchFault` are valid.
- `Compressed` output 1: high when `Instr[1:0] != 2'b11`.
- `FetchFault` output 1: misaligned fetch (`FetchAddr[0]=1`).
- `FetchBusy` output 1: high in any state other than IDLE.

## Operation
- The state machine has five states: IDLE, REQ_LO, REQ_HI, DRAIN, VALID.
- **IDLE + `FetchReq`:**
  - If `FetchAddr[0]=1`, go to VALID with `FetchFault=1`, `Instr=0`, `Compressed=0`. No memory access is made.
  - Otherwise latch the address and go to REQ_LO, or take the buffer path (see Configuration).
- **REQ_LO:**
  - `MemReq=1`, `MemAddr={addr[31:2],2'b00}`.
  - On `MemAck`, form the halfword `h` (`w[15:0]` if `addr[1]=0`, else `w[31:16]`).
  - If `h[1:0]!=2'b11`: `Instr={16'h0,h}` and go to VALID.
  - Else if `addr[1]=0`: `Instr=w` and go to VALID.
  - Else hold `h` in `HalfLo` and go to REQ_HI.
- **REQ_HI:**
  - `MemReq=1`, `MemAddr={addr[31:2]+1,2'b00}`. The word index wraps modulo 2^30, so address 0xFFFFFFFE fetches its upper half from 0x00000000.
  - On `MemAck`: `Instr={MemRData[15:0],HalfLo}` and go to VALID.
- **VALID:**
  - `InstrValid=1`; outputs stay stable until `InstrValid & InstrReady`.
  - In the consume cycle, a simultaneous `FetchReq` is accepted exactly as from IDLE, with no bubble. Otherwise go to IDLE.
- **Redirect:**
  - `FetchReq` in REQ_LO or REQ_HI latches the new address into a pending register and moves to DRAIN.
  - `MemReq` and `MemAddr` never change before `MemAck`. DRAIN holds the outstanding request until `MemAck` and discards the data, then starts the pending fetch as from IDLE.
  - A further `FetchReq` in DRAIN overwrites the pending address.
- `FetchReq` in VALID without `InstrReady` is ignored; the core must not issue it.
- `Invalidate` has no effect on an in-flight fetch.

## Timing
- **Reset values:** `MemReq=0`, `MemAddr=0`, `Instr=0`, `InstrValid=0`, `Compressed=0`, `FetchFault=0`, `FetchBusy=0`; state IDLE; buffer invalid.
- **Reset mid-operation:** `MemReq` drops immediately and the transaction is abandoned. Memory tolerates an abandoned request.
- `MemReq` rises in the cycle after `FetchReq` is accepted. It is held with `MemAddr` stable until the `MemAck` cycle, and deasserts in the following cycle unless the next state issues a new request.
- `MemAck` may be high in the first cycle of `MemReq` (zero-wait memory).
- **Latency with zero-wait memory, `FetchReq` at cycle 0:**
  - single word: `InstrValid` at cycle 2;
  - split instruction: cycle 3;
  - fault: cycle 1;
  - buffer hit: cycle 1.
- `Instr`, `Compressed`, `FetchFault` and `InstrValid` are all registered.

## Configuration
- **`FETCH_WORD_BUF_EN` defined:**
  - A one-word buffer (valid, tag `[31:2]`, data) captures every `MemAck` word that is not discarded.
  - On accept, if the buffer is valid and the tag equals `FetchAddr[31:2]`, the low word is taken from the buffer. REQ_LO is skipped, going straight to VALID or REQ_HI.
  - `Invalidate` and reset clear the valid bit. An `Invalidate` and a buffer write in the same cycle leave the buffer invalid.
- **`FETCH_WORD_BUF_EN` undefined:** no buffer; every fetch reads memory; `Invalidate` is ignored.

## Structure
- Package `fetch_pkg` holds:
  - the state enum typedef (IDLE, REQ_LO, REQ_HI, DRAIN, VALID);
  - constant `OPC_QUAD_FULL = 2'b11`;
  - the halfword/word alignment helper function.
- Sub-module `fetch_word_buf`: tag, data and valid storage with lookup and clear. It is instantiated only under `FETCH_WORD_BUF_EN`.

## Test plan
- **Aligned 32-bit:** `FetchAddr=0x100`, mem[0x100]=0x00A00093, zero-wait → `MemAddr=0x100`, `InstrValid` at cycle 2, `Instr=0x00A00093`, `Compressed=0`.
- **Compressed at halfword 2:** `FetchAddr=0x102`, mem[0x100]=0x4501_0000 → one memory read, `Instr=0x00004501`, `Compressed=1`.
- **Split instruction:** `FetchAddr=0x106`, mem[0x104]=0x0093_xxxx, mem[0x108]=0xxxxx_00A0 → two reads at 0x104 and 0x108, `Instr=0x00A00093`, `InstrValid` at cycle 3.
- **Wrap-around:** `FetchAddr=0xFFFFFFFE`, high half 0x0093, next word at 0x00000000 with low half 0x00A0 → second `MemAddr=0x00000000`, `Instr=0x00A00093`.
- **Redirect:** `FetchReq` to 0x200 while REQ_LO waits 3 cycles for `MemAck` → `MemAddr` stays 0x100 until ack, the data is dropped, the next `MemAddr=0x200`, and only the 0x200 instruction is presented.
- **Fault and buffer:**
  - `FetchAddr=0x101` → `FetchFault=1` at cycle 1, no `MemReq`.
  - With `FETCH_WORD_BUF_EN`: fetch 0x100 then 0x102 (compressed) → the second fetch has no `MemReq` and is valid at cycle 1.
  - After `Invalidate`, 0x102 reads memory.
